// File: rtl/uart_rx_param_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // 50 MHz system clock at 115200 baud
    localparam int unsigned DefaultClksPerBit = 434;

endpackage

// File: rtl/uart_rx_param_if.sv
`timescale 1ns/1ps
// Receiver-to-consumer bus: hold register contents, error flags and the read strobe.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rd_en;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        input  rd_en,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output break_det,
        output overrun_err,
        output busy
    );

    modport slave (
        output rd_en,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  break_det,
        input  overrun_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_param_sync.sv
`timescale 1ns/1ps
// Multi-stage synchroniser for the asynchronous serial line plus falling-edge detect.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_i};
    end

    // Reset to the idle-high line level so reset never looks like a start bit
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rx_o   = sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Parametrised UART receiver: mid-bit sampling FSM, shift register and a one-entry
// hold register with valid/read handshake and frame, parity, break and overrun reporting.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      rx_uart_i,
    uart_rx_if.master rx_bus
);
    localparam int unsigned CntW      = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW      = $clog2(DATA_BITS + 1);
    localparam parity_e     ParMode   = parity_e'(PARITY[1:0]);
    localparam bit          HasParity = (ParMode != PAR_NONE);
    localparam bit          OddParity = (ParMode == PAR_ODD);

    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
        $error("CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_chk_par
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end

    logic line, fall;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .rx_i  (rx_uart_i),
        .rx_o  (line),
        .fall_o(fall)
    );

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 ferr_q, ferr_d;
    logic                 done_q, done_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 fout_q, fout_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;

    logic busy, arm_done, half_tick, full_tick, last_data, last_stop;
    logic perr_new, brk_new;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ARM:    if (arm_done) state_d = ST_IDLE;
            ST_IDLE:   if (fall) state_d = ST_START;
            ST_START:  if (half_tick) state_d = line ? ST_IDLE : ST_DATA;
            ST_DATA:   if (last_data) state_d = HasParity ? ST_PARITY : ST_STOP;
            ST_PARITY: if (full_tick) state_d = ST_STOP;
            ST_STOP:   if (last_stop) state_d = ST_IDLE;
            default:   state_d = ST_ARM;
        endcase
    end

    // Decoded strobes and status output
    always_comb begin
        busy      = (state_q != ST_ARM) && (state_q != ST_IDLE);
        full_tick = (cnt_q == CntW'(CLKS_PER_BIT - 1));
        arm_done  = (state_q == ST_ARM) && line && full_tick;
        half_tick = (state_q == ST_START) && (cnt_q == CntW'(CLKS_PER_BIT / 2 - 1));
        last_data = (state_q == ST_DATA) && full_tick && (bit_q == BitW'(DATA_BITS - 1));
        last_stop = (state_q == ST_STOP) && full_tick && (bit_q == BitW'(STOP_BITS - 1));
    end

    // Counters and shift register
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        done_d  = last_stop;
        unique case (state_q)
            ST_ARM: begin
                // Any low sample restarts the quiet-line count
                cnt_d = (line && !arm_done) ? cnt_q + CntW'(1) : '0;
            end
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            ST_START: begin
                cnt_d = half_tick ? '0 : cnt_q + CntW'(1);
                if (half_tick) begin
                    ferr_d = 1'b0;
                    par_d  = 1'b0;
                end
            end
            ST_DATA: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    bit_d   = last_data ? '0 : bit_q + BitW'(1);
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_PARITY: begin
                if (full_tick) begin
                    cnt_d = '0;
                    par_d = line;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ST_STOP: begin
                if (full_tick) begin
                    cnt_d = '0;
                    bit_d = last_stop ? '0 : bit_q + BitW'(1);
                    if (!line) ferr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Hold register: commit one cycle after the last stop sample
    always_comb begin
        perr_new = HasParity && ((^{shift_q, par_q}) != OddParity);
        brk_new  = ferr_q && (shift_q == '0) && !(HasParity && par_q);
        data_d   = data_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        fout_d   = fout_q;
        brk_d    = brk_q;
        ovr_d    = 1'b0;
        if (done_q) begin
            if (valid_q && !rx_bus.rd_en) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
                perr_d  = perr_new;
                fout_d  = ferr_q;
                brk_d   = brk_new;
            end
        end else if (rx_bus.rd_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            ferr_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            fout_q  <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            ferr_q  <= ferr_d;
            done_q  <= done_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            fout_q  <= fout_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_bus.rx_data     = data_q;
    assign rx_bus.rx_valid    = valid_q;
    assign rx_bus.parity_err  = perr_q;
    assign rx_bus.frame_err   = fout_q;
    assign rx_bus.break_det   = brk_q;
    assign rx_bus.overrun_err = ovr_q;
    assign rx_bus.busy        = busy;
endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Directed and randomised bench for uart_rx_param with three configurations:
// 8N1, 8E1 and 8O2, all at 4 clocks per bit.
module tb_uart_rx_param;
    localparam int unsigned Cpb = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] line;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         ov_cnt[3];

    always #10 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) if0 ();
    uart_rx_if #(.DATA_BITS(8)) if1 ();
    uart_rx_if #(.DATA_BITS(8)) if2 ();

    uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .SYNC_STAGES(2)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .rx_uart_i(line[0]), .rx_bus(if0.master));
    uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                    .SYNC_STAGES(2)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .rx_uart_i(line[1]), .rx_bus(if1.master));
    uart_rx_param #(.CLKS_PER_BIT(Cpb), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2),
                    .SYNC_STAGES(2)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .rx_uart_i(line[2]), .rx_bus(if2.master));

    initial begin
        ov_cnt[0] = 0;
        ov_cnt[1] = 0;
        ov_cnt[2] = 0;
    end

    always @(posedge clk) begin
        ov_cnt[0] <= ov_cnt[0] + int'(if0.overrun_err);
        ov_cnt[1] <= ov_cnt[1] + int'(if1.overrun_err);
        ov_cnt[2] <= ov_cnt[2] + int'(if2.overrun_err);
    end

    function automatic int par_of(input int sel);
        return (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
    endfunction

    function automatic int nstop_of(input int sel);
        return (sel == 2) ? 2 : 1;
    endfunction

    function automatic int bits_after_start(input int sel);
        return 8 + ((par_of(sel) != 0) ? 1 : 0) + nstop_of(sel);
    endfunction

    // Line fall to rx_valid, in clocks, with SYNC_STAGES = 2
    function automatic int latency(input int sel);
        return 2 + 1 + Cpb / 2 + bits_after_start(sel) * Cpb + 1;
    endfunction

    // Expected {break, frame, parity} from the frame as sent on the wire
    function automatic logic [2:0] model_flags(input int sel, input logic [7:0] d,
                                               input logic p, input logic [1:0] st);
        int   ones;
        logic pe, fe, br;
        ones = $countones(d) + int'(p);
        if (par_of(sel) == 0)      pe = 1'b0;
        else if (par_of(sel) == 1) pe = (ones % 2 == 0);
        else                       pe = (ones % 2 == 1);
        fe = !st[0] || (nstop_of(sel) == 2 && !st[1]);
        br = fe && (d == 8'h00) && (par_of(sel) == 0 || !p);
        return {br, fe, pe};
    endfunction

    // {busy, overrun, break, frame, parity, valid, data[7:0]}
    function automatic logic [13:0] snap(input int sel);
        case (sel)
            0: return {if0.busy, if0.overrun_err, if0.break_det, if0.frame_err, if0.parity_err,
                       if0.rx_valid, if0.rx_data};
            1: return {if1.busy, if1.overrun_err, if1.break_det, if1.frame_err, if1.parity_err,
                       if1.rx_valid, if1.rx_data};
            default: return {if2.busy, if2.overrun_err, if2.break_det, if2.frame_err,
                             if2.parity_err, if2.rx_valid, if2.rx_data};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int sel, input logic v);
        case (sel)
            0: if0.rd_en = v;
            1: if1.rd_en = v;
            default: if2.rd_en = v;
        endcase
    endtask

    task automatic drive_bit(input int sel, input logic v);
        line[sel] = v;
        repeat (Cpb) tick();
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                              input logic [1:0] st);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_of(sel) != 0) drive_bit(sel, p);
        for (int i = 0; i < nstop_of(sel); i++) drive_bit(sel, st[i]);
    endtask

    task automatic idle(input int sel, input int n);
        line[sel] = 1'b1;
        repeat (n) tick();
    endtask

    // Called right after send_frame; checks the commit lands exactly at the computed latency
    task automatic expect_commit(input int sel, input logic [7:0] d, input logic p,
                                 input logic [1:0] st, input string tag);
        logic [13:0] s;
        int          rem;
        rem = latency(sel) - Cpb * (1 + bits_after_start(sel));
        repeat (rem - 1) tick();
        s = snap(sel);
        check({tag, "_early"}, 32'(s[8]), 32'd0);
        tick();
        s = snap(sel);
        check({tag, "_valid"}, 32'(s[8]), 32'd1);
        check({tag, "_data"}, 32'(s[7:0]), 32'(d));
        check({tag, "_flags"}, 32'(s[11:9]), 32'(model_flags(sel, d, p, st)));
    endtask

    task automatic do_read(input int sel, input logic [7:0] d, input string tag);
        logic [13:0] s;
        set_rd(sel, 1'b1);
        tick();
        set_rd(sel, 1'b0);
        s = snap(sel);
        check({tag, "_rdclr"}, 32'(s[8]), 32'd0);
        check({tag, "_hold"}, 32'(s[7:0]), 32'(d));
    endtask

    task automatic watch(input int sel, input int n, output logic saw_busy,
                         output logic saw_valid);
        logic [13:0] s;
        saw_busy  = 1'b0;
        saw_valid = 1'b0;
        repeat (n) begin
            tick();
            s = snap(sel);
            saw_busy  = saw_busy | s[13];
            saw_valid = saw_valid | s[8];
        end
    endtask

    initial begin
        logic [13:0] s;
        logic        sb, sv;
        int          ov0;
        logic [7:0]  rd;
        logic        rp;
        logic [1:0]  rs;
        int          sel;

        rst_n = 1'b0;
        line  = '1;
        if0.rd_en = 1'b0;
        if1.rd_en = 1'b0;
        if2.rd_en = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) check("reset_state", 32'(snap(i)), 32'd0);
        rst_n = 1'b1;
        repeat (12) tick();

        // Single 8N1 frame with latency check
        send_frame(0, 8'h3A, 1'b0, 2'b11);
        expect_commit(0, 8'h3A, 1'b0, 2'b11, "n81_3a");
        do_read(0, 8'h3A, "n81_3a");
        idle(0, 2 * Cpb);

        // Back-to-back frames, read of the first overlaps the second frame
        ov0 = ov_cnt[0];
        send_frame(0, 8'h3A, 1'b0, 2'b11);
        fork
            send_frame(0, 8'hC5, 1'b0, 2'b11);
            begin
                repeat (latency(0) - Cpb * (1 + bits_after_start(0))) tick();
                s = snap(0);
                check("b2b_first_valid", 32'(s[8]), 32'd1);
                check("b2b_first_data", 32'(s[7:0]), 32'h3A);
                do_read(0, 8'h3A, "b2b_first");
            end
        join
        expect_commit(0, 8'hC5, 1'b0, 2'b11, "b2b_second");
        do_read(0, 8'hC5, "b2b_second");
        check("b2b_no_overrun", 32'(ov_cnt[0] - ov0), 32'd0);
        idle(0, 2 * Cpb);

        // Even and odd parity, both parity bit values
        for (int sl = 1; sl <= 2; sl++) begin
            for (int pb = 0; pb < 2; pb++) begin
                send_frame(sl, 8'h3A, pb[0], 2'b11);
                expect_commit(sl, 8'h3A, pb[0], 2'b11, "par");
                do_read(sl, 8'h3A, "par");
                idle(sl, 2 * Cpb);
            end
        end

        // Stop bit forced low
        send_frame(0, 8'h55, 1'b0, 2'b00);
        expect_commit(0, 8'h55, 1'b0, 2'b00, "frame_err");
        do_read(0, 8'h55, "frame_err");
        idle(0, 2 * Cpb);

        // Break: line low for 12 bit times
        line[0] = 1'b0;
        repeat (latency(0) - 1) tick();
        check("break_early", 32'(snap(0) >> 8 & 14'h1), 32'd0);
        tick();
        s = snap(0);
        check("break_valid", 32'(s[8]), 32'd1);
        check("break_data", 32'(s[7:0]), 32'd0);
        check("break_flags", 32'(s[11:9]), 32'b110);
        repeat (12 * Cpb - latency(0)) tick();
        idle(0, 2 * Cpb);
        do_read(0, 8'h00, "break");

        // One-clock glitch: START entered, then abandoned silently
        line[0] = 1'b0;
        tick();
        line[0] = 1'b1;
        repeat (2) tick();
        check("glitch_start_seen", 32'(snap(0) >> 13), 32'd1);
        repeat (5) tick();
        check("glitch_busy_clear", 32'(snap(0) >> 13), 32'd0);
        watch(0, 12 * Cpb, sb, sv);
        check("glitch_no_valid", 32'(sv), 32'd0);

        // Overrun: second commit with hold register full
        ov0 = ov_cnt[0];
        send_frame(0, 8'h3A, 1'b0, 2'b11);
        expect_commit(0, 8'h3A, 1'b0, 2'b11, "ovr_first");
        idle(0, 2 * Cpb);
        send_frame(0, 8'h81, 1'b0, 2'b11);
        repeat (latency(0) - Cpb * (1 + bits_after_start(0))) tick();
        s = snap(0);
        check("ovr_pulse", 32'(s[12]), 32'd1);
        check("ovr_keep_data", 32'(s[7:0]), 32'h3A);
        check("ovr_keep_valid", 32'(s[8]), 32'd1);
        tick();
        check("ovr_pulse_end", 32'(snap(0) >> 12 & 14'h1), 32'd0);
        do_read(0, 8'h3A, "ovr");
        check("ovr_count", 32'(ov_cnt[0] - ov0), 32'd1);
        idle(0, 2 * Cpb);

        // Reset mid-frame with the line held low, then a short high pulse
        line[0] = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        watch(0, 20, sb, sv);
        check("rst_mid_no_busy", 32'(sb), 32'd0);
        check("rst_mid_no_valid", 32'(sv), 32'd0);
        line[0] = 1'b1;
        repeat (2) tick();
        line[0] = 1'b0;
        watch(0, 10 * Cpb, sb, sv);
        check("arm_short_high_no_start", 32'(sb), 32'd0);
        check("arm_short_high_no_valid", 32'(sv), 32'd0);
        idle(0, 10);
        send_frame(0, 8'h81, 1'b0, 2'b11);
        expect_commit(0, 8'h81, 1'b0, 2'b11, "post_rst");
        do_read(0, 8'h81, "post_rst");
        idle(0, 2 * Cpb);

        // Randomised frames across all three configurations
        for (int i = 0; i < 15; i++) begin
            sel = i % 3;
            rd  = 8'($urandom);
            rp  = 1'($urandom);
            rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 5) == 0) rd = 8'h00;
            send_frame(sel, rd, rp, rs);
            expect_commit(sel, rd, rp, rs, "rand");
            do_read(sel, rd, "rand");
            idle(sel, 2 * Cpb);
        end
        check("rand_no_overrun", 32'(ov_cnt[1] + ov_cnt[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
